// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO.
// MULT/MULTU/DIV/DIVU take WIDTH+1 cycles; MTHI/MTLO complete at the accepting edge.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In_A,
    input  logic [WIDTH-1:0] In_B,
    input  logic [2:0]       Op,
    input  logic             Start,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               div_zero_q, div_zero_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        signed_op = ~Op[0];
        mag_a     = (signed_op && In_A[WIDTH-1]) ? -In_A : In_A;
        mag_b     = (signed_op && In_B[WIDTH-1]) ? -In_B : In_B;
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, quo_q[WIDTH-1]};
        // Sign bit of a WIDTH+1 bit difference is exact because rem_q < opnd_q.
        div_diff  = div_shift - {1'b0, opnd_q};
        prod_fix  = neg_res_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        div_zero_d = div_zero_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    if (!Op[2]) begin
                        is_div_d   = Op[1];
                        neg_res_d  = signed_op & (In_A[WIDTH-1] ^ In_B[WIDTH-1]);
                        neg_rem_d  = signed_op & In_A[WIDTH-1];
                        cnt_d      = '0;
                        div_zero_d = 1'b0;
                        if (Op[1]) begin
                            opnd_d = mag_b;
                            rem_d  = '0;
                            quo_d  = mag_a;
                            if (In_B == '0) begin
                                // Remainder register carries the raw dividend straight to HI.
                                div_zero_d = 1'b1;
                                rem_d      = In_A;
                                state_d    = StFinish;
                            end else begin
                                state_d = StCalc;
                            end
                        end else begin
                            opnd_d  = mag_a;
                            acc_d   = {{WIDTH{1'b0}}, mag_b};
                            state_d = StCalc;
                        end
                    end else if (Op == 3'b100) begin
                        hi_d = In_A;
                    end else if (Op == 3'b101) begin
                        lo_d = In_A;
                    end
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        rem_d = div_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                if (div_zero_q) begin
                    hi_d = rem_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = neg_rem_q ? -rem_q : rem_q;
                    lo_d = neg_res_q ? -quo_q : quo_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            div_zero_q <= div_zero_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = (state_q != StIdle);
    assign Done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] In_A;
    logic [31:0] In_B;
    logic [2:0]  Op;
    logic        Start;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    int passed;
    int total;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .In_A  (In_A),
        .In_B  (In_B),
        .Op    (Op),
        .Start (Start),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one operation and waits for Done; inject_at >= 0 asserts a stray DIVU start
    // at that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at,
                          input int exp_busy, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int busy_cyc;
        @(negedge Clk);
        Op    = op;
        In_A  = a;
        In_B  = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        busy_cyc = 0;
        for (int n = 0; n < 100 && !Done; n++) begin
            if (Busy) busy_cyc++;
            if (n == inject_at) begin
                Op    = 3'b011;
                In_A  = 32'd9;
                In_B  = 32'd3;
                Start = 1'b1;
            end
            @(posedge Clk);
            #1;
            Start = 1'b0;
        end
        check_eq({tag, "_done"}, 64'(Done), 64'd1);
        check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
        check_eq({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
        check_eq({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
        check_eq({tag, "_busy_at_done"}, 64'(Busy), 64'd0);
        @(posedge Clk);
        #1;
        check_eq({tag, "_done_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        Reset  = 1'b0;
        Start  = 1'b0;
        Op     = 3'b000;
        In_A   = '0;
        In_B   = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_hi", 64'(Hi), 64'd0);
        check_eq("rst_lo", 64'(Lo), 64'd0);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;

        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 33,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, -1, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000, -1, 33,
               32'h4000_0000, 32'h0000_0000);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, -1, 33,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'b011, 32'd100, 32'd7, -1, 33, 32'd2, 32'd14);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, -1, 33,
               32'h0000_0000, 32'h8000_0000);
        run_op("divu_zero", 3'b011, 32'h0000_1234, 32'd0, -1, 1,
               32'h0000_1234, 32'hFFFF_FFFF);
        run_op("multu_inject", 3'b001, 32'd5, 32'd6, 10, 33, 32'd0, 32'd30);

        @(negedge Clk);
        Op    = 3'b100;
        In_A  = 32'h0000_ABCD;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check_eq("mthi_hi", 64'(Hi), 64'h0000_ABCD);
        check_eq("mthi_lo", 64'(Lo), 64'd30);
        check_eq("mthi_busy", 64'(Busy), 64'd0);
        check_eq("mthi_done", 64'(Done), 64'd0);

        @(negedge Clk);
        Op    = 3'b101;
        In_A  = 32'h1357_2468;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check_eq("mtlo_lo", 64'(Lo), 64'h1357_2468);
        check_eq("mtlo_hi", 64'(Hi), 64'h0000_ABCD);

        @(negedge Clk);
        Op    = 3'b110;
        In_A  = 32'hDEAD_BEEF;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check_eq("nop_busy", 64'(Busy), 64'd0);
        check_eq("nop_hilo", {Hi, Lo}, {32'h0000_ABCD, 32'h1357_2468});

        @(negedge Clk);
        Op    = 3'b000;
        In_A  = 32'd3;
        In_B  = 32'd7;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (14) @(posedge Clk);
        #3;
        check_eq("mid_busy", 64'(Busy), 64'd1);
        Reset = 1'b0;
        #1;
        check_eq("arst_hi", 64'(Hi), 64'd0);
        check_eq("arst_lo", 64'(Lo), 64'd0);
        check_eq("arst_busy", 64'(Busy), 64'd0);
        check_eq("arst_done", 64'(Done), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;

        run_op("divu_after_rst", 3'b011, 32'd10, 32'd3, -1, 33, 32'd1, 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
